// File: rtl/grey_loader_if.sv
// Handshake and memory-port bundle between the greyscale loader, the image
// memory and the pyramid level-0 frame buffer.
interface grey_loader_if #(
  parameter int AW = 14
);
  logic          start_in;
  logic          busy_out;
  logic          done_out;
  logic [AW-1:0] img_addr_out;
  logic [11:0]   img_data_in;
  logic [AW-1:0] grey_addr_out;
  logic [7:0]    grey_data_out;
  logic          grey_valid_out;

  modport master (
    input  start_in, img_data_in,
    output busy_out, done_out, img_addr_out, grey_addr_out, grey_data_out, grey_valid_out
  );

  modport slave (
    output start_in, img_data_in,
    input  busy_out, done_out, img_addr_out, grey_addr_out, grey_data_out, grey_valid_out
  );
endinterface

// File: rtl/grey_loader.sv
// Start/done sequencer: reads one RGB444 frame in raster order, converts each
// pixel to 8-bit luma and writes it to level 0 of the pyramid frame buffer.
module grey_loader #(
  parameter int WIDTH      = 128,
  parameter int HEIGHT     = 128,
  parameter int RD_LATENCY = 2
) (
  input  logic          clk_100mhz,
  input  logic          sys_rst,
  grey_loader_if.master bus
);
  localparam int N         = WIDTH * HEIGHT;
  localparam int AW        = $clog2(N);
  localparam int DRAIN_LEN = RD_LATENCY + 2;
  localparam int DW        = $clog2(DRAIN_LEN + 1);
  // Read latency plus the two conversion stages.
  localparam int STG       = RD_LATENCY + 2;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t        state, state_nx;
  logic [AW-1:0] rd_addr, rd_addr_nx;
  logic [DW-1:0] drn_cnt, drn_cnt_nx;
  logic          done_q, done_nx;

  logic [STG:0]         vld_pipe;
  logic [STG:0][AW-1:0] addr_pipe;

  logic [7:0]  r8, g8, b8;
  logic [15:0] p_r, p_g, p_b, lum_sum;
  logic [7:0]  grey_q;

  always_ff @(posedge clk_100mhz) begin
    if (sys_rst) begin
      state   <= IDLE;
      rd_addr <= '0;
      drn_cnt <= '0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      rd_addr <= rd_addr_nx;
      drn_cnt <= drn_cnt_nx;
      done_q  <= done_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    rd_addr_nx = rd_addr;
    drn_cnt_nx = drn_cnt;
    done_nx    = 1'b0;
    case (state)
      IDLE: begin
        rd_addr_nx = '0;
        drn_cnt_nx = '0;
        if (bus.start_in) state_nx = READ;
      end
      READ: begin
        if (rd_addr == AW'(N - 1)) begin
          state_nx   = DRAIN;
          rd_addr_nx = '0;
          drn_cnt_nx = '0;
        end else begin
          rd_addr_nx = rd_addr + 1'b1;
        end
      end
      DRAIN: begin
        // Hold until the last issued pixel has left the conversion pipe.
        if (drn_cnt == DW'(DRAIN_LEN - 1)) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end else begin
          drn_cnt_nx = drn_cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Slot 0 tracks the registered read address; slot RD_LATENCY lines up with
  // img_data_in and slot STG with the registered grey output.
  always_ff @(posedge clk_100mhz) begin
    if (sys_rst) begin
      vld_pipe  <= '0;
      addr_pipe <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[STG-1:0], state_nx == READ};
      addr_pipe <= {addr_pipe[STG-1:0], rd_addr_nx};
    end
  end

  assign r8 = {bus.img_data_in[11:8], bus.img_data_in[11:8]};
  assign g8 = {bus.img_data_in[7:4],  bus.img_data_in[7:4]};
  assign b8 = {bus.img_data_in[3:0],  bus.img_data_in[3:0]};

  // Weights sum to 256, so a full-scale pixel lands exactly on 65280.
  assign lum_sum = p_r + p_g + p_b;

  always_ff @(posedge clk_100mhz) begin
    if (sys_rst) begin
      p_r    <= '0;
      p_g    <= '0;
      p_b    <= '0;
      grey_q <= '0;
    end else begin
      p_r    <= 16'(r8) * 16'd77;
      p_g    <= 16'(g8) * 16'd150;
      p_b    <= 16'(b8) * 16'd29;
      grey_q <= lum_sum[15:8];
    end
  end

  assign bus.busy_out       = (state != IDLE);
  assign bus.done_out       = done_q;
  assign bus.img_addr_out   = rd_addr;
  assign bus.grey_addr_out  = addr_pipe[STG];
  assign bus.grey_data_out  = grey_q;
  assign bus.grey_valid_out = vld_pipe[STG];
endmodule
